// File: rtl/pxbf_writer_pkg.sv
// Shared types and helpers for the SRAM pixel writer: bus widths,
// controller states, the queued command record and the address helper.
package pxbf_writer_pkg;

    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 16;
    localparam int X_W        = 9;
    localparam int Y_W        = 8;
    localparam int BE_W       = 2;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic              read;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [DATA_W-1:0] color;
        logic [BE_W-1:0]   byteenable;
    } cmd_t;

    // Linear frame-buffer word address, wrapping inside the 20-bit SRAM space.
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic [ADDR_W-1:0] base,
        input logic [X_W-1:0]    x,
        input logic [Y_W-1:0]    y,
        input int                h_res
    );
        logic [31:0] sum;
        sum = 32'(base) + (32'(y) * 32'(h_res)) + 32'(x);
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/pxbf_cmd_fifo.sv
// Four-entry synchronous command queue with registered full/empty flags.
// Full is held high in reset so the producer sees "not ready" until the
// first clock after release.
module pxbf_cmd_fifo
    import pxbf_writer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       full_q, full_d;
    logic       empty_q, empty_d;
    cmd_t       mem_q [FIFO_DEPTH];
    cmd_t       mem_d [FIFO_DEPTH];
    logic       do_push;
    logic       do_pop;

    assign do_push  = push && !full_q;
    assign do_pop   = pop && !empty_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

    // Pointer, occupancy and storage update for one push and/or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 3'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 3'd1;
        end
        full_d  = (count_d == 3'(FIFO_DEPTH));
        empty_d = (count_d == 3'd0);
    end

    // Control registers; flushed asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            full_q   <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Entry storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sram_pixel_writer.sv
// Queued pixel read/write engine for an asynchronous frame-buffer SRAM.
// Each bus cycle is SETUP, STROBE_CYCLES of STROBE, then HOLD; a queued
// command popped in HOLD chains straight into the next SETUP.
module sram_pixel_writer
    import pxbf_writer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE       = 20'h00000,
    parameter int                H_RES         = 320,
    parameter int                V_RES         = 240,
    parameter int                STROBE_CYCLES = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [X_W-1:0]    cmd_x,
    input  logic [Y_W-1:0]    cmd_y,
    input  logic [DATA_W-1:0] cmd_color,
    input  logic [BE_W-1:0]   cmd_byteenable,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err_oob,
    output logic              sram_write,
    output logic              sram_chipselect,
    output logic              sram_outputenable,
    output logic [ADDR_W-1:0] sram_address,
    output logic [BE_W-1:0]   sram_byteenable,
    inout  wire  [DATA_W-1:0] sram_data_io
);

    state_e              state_q, state_d;
    logic [3:0]          strobe_cnt_q, strobe_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   color_q, color_d;
    logic                is_read_q, is_read_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                err_oob_q, err_oob_d;

    cmd_t                push_cmd;
    cmd_t                head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                load_cmd;
    logic                drop_cmd;
    logic                head_oob;
    logic                last_strobe;
    logic                drive_bus;

    assign push_cmd = '{read: cmd_read, x: cmd_x, y: cmd_y,
                        color: cmd_color, byteenable: cmd_byteenable};

    pxbf_cmd_fifo u_fifo (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready   = !fifo_full;
    assign head_oob    = ({23'd0, head.x} >= 32'(H_RES)) || ({24'd0, head.y} >= 32'(V_RES));
    assign last_strobe = (strobe_cnt_q == 4'(STROBE_CYCLES - 1));

    // State register, cleared asynchronously so strobes drop at once.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; IDLE and HOLD both pop the queue head when one is waiting.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load_cmd = 1'b0;
        drop_cmd = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                state_d = ST_IDLE;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_oob) begin
                        drop_cmd = 1'b1;
                    end else begin
                        load_cmd = 1'b1;
                        state_d  = ST_SETUP;
                    end
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: if (last_strobe) state_d = ST_HOLD;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Transaction datapath: latch the popped command and capture read data.
    always_comb begin
        strobe_cnt_d = (state_q == ST_STROBE) ? strobe_cnt_q + 4'd1 : 4'd0;
        addr_d       = addr_q;
        be_d         = be_q;
        color_d      = color_q;
        is_read_d    = is_read_q;
        rd_data_d    = rd_data_q;
        err_oob_d    = drop_cmd;
        if (load_cmd) begin
            addr_d    = pixel_addr(FB_BASE, head.x, head.y, H_RES);
            be_d      = head.read ? 2'b11 : head.byteenable;
            color_d   = head.color;
            is_read_d = head.read;
        end
        if ((state_q == ST_STROBE) && last_strobe && is_read_q) begin
            rd_data_d = sram_data_io;
        end
    end

    // Datapath registers with asynchronous reset.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            strobe_cnt_q <= 4'd0;
            addr_q       <= '0;
            be_q         <= '0;
            color_q      <= '0;
            is_read_q    <= 1'b0;
            rd_data_q    <= '0;
            err_oob_q    <= 1'b0;
        end else begin
            strobe_cnt_q <= strobe_cnt_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            color_q      <= color_d;
            is_read_q    <= is_read_d;
            rd_data_q    <= rd_data_d;
            err_oob_q    <= err_oob_d;
        end
    end

    // Bus strobes and status decoded from the current state.
    always_comb begin
        sram_chipselect   = (state_q != ST_IDLE);
        sram_write        = (state_q == ST_STROBE) && !is_read_q;
        sram_outputenable = (state_q == ST_STROBE) && is_read_q;
        drive_bus         = (state_q != ST_IDLE) && !is_read_q;
        rd_valid          = (state_q == ST_HOLD) && is_read_q;
        busy              = (state_q != ST_IDLE) || !fifo_empty;
        sram_address      = addr_q;
        sram_byteenable   = be_q;
        rd_data           = rd_data_q;
        err_oob           = err_oob_q;
    end

    assign sram_data_io = drive_bus ? color_q : {DATA_W{1'bz}};

endmodule
